// File: rtl/doe_defines_pkg.sv
// Shared constants and FSM state type for the CBC chaining wrapper.
package doe_defines_pkg;

   localparam int DOE_BLK_W = 128;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_REQ   = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DRAIN = 3'd4,
      ST_DONE  = 3'd5
   } doe_chain_state_e;

endpackage

// File: rtl/doe_blk_shifter.sv
// 128-bit block register that shifts DATA_WIDTH words in at the bottom and
// presents the top word; used both to pack input words and unpack results.
module doe_blk_shifter
   import doe_defines_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  clr_i,
   input  logic                  load_i,
   input  logic [DOE_BLK_W-1:0]  load_blk_i,
   input  logic                  shift_i,
   input  logic [DATA_WIDTH-1:0] word_i,
   output logic [DOE_BLK_W-1:0]  blk_o,
   output logic                  last_o
);

   localparam int WPB   = DOE_BLK_W / DATA_WIDTH;
   localparam int CNT_W = $clog2(WPB);

   logic [DOE_BLK_W-1:0] blk_q, blk_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   always_comb begin
      blk_d = blk_q;
      cnt_d = cnt_q;
      if (load_i) begin
         blk_d = load_blk_i;
         cnt_d = '0;
      end else if (shift_i) begin
         // First word ends up in the top slot after WPB shifts.
         blk_d = {blk_q[DOE_BLK_W-DATA_WIDTH-1:0], word_i};
         cnt_d = (cnt_q == CNT_W'(WPB - 1)) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (clr_i) begin
         blk_q <= '0;
         cnt_q <= '0;
      end else begin
         blk_q <= blk_d;
         cnt_q <= cnt_d;
      end
   end

   assign blk_o  = blk_q;
   assign last_o = (cnt_q == CNT_W'(WPB - 1));

endmodule

// File: rtl/doe_cbc_chain.sv
// CBC chaining wrapper: packs stream words into blocks, chains them around an
// external AES core, and unpacks results back onto the output stream.
module doe_cbc_chain
   import doe_defines_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int BLK_CNT_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  zeroize,
   input  logic                  start,
   input  logic                  encdec,
   input  logic [BLK_CNT_W-1:0]  num_blocks,
   input  logic [DOE_BLK_W-1:0]  iv,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   input  logic                  src_valid,
   output logic                  src_ready,
   input  logic [DATA_WIDTH-1:0] src_data,
   output logic                  dst_valid,
   input  logic                  dst_ready,
   output logic [DATA_WIDTH-1:0] dst_data,
   output logic                  core_next,
   output logic [DOE_BLK_W-1:0]  core_block,
   input  logic                  core_ready,
   input  logic [DOE_BLK_W-1:0]  core_result,
   input  logic                  core_valid,
   output doe_chain_state_e      dbg_state_o
);

   doe_chain_state_e     state_q, state_d;
   logic                 enc_q, enc_d;
   logic                 err_q, err_d;
   logic [BLK_CNT_W-1:0] cnt_q, cnt_d;
   logic [DOE_BLK_W-1:0] chain_q, chain_d;
   logic [DOE_BLK_W-1:0] in_blk, out_blk, out_load;
   logic                 clr, src_fire, dst_fire, in_last, out_last, out_load_en;

   // A word moves on either stream only when valid && ready in the same cycle;
   // a wipe cycle never offers a handshake.
   assign clr         = rst | zeroize;
   assign src_ready   = (state_q == ST_LOAD) & ~clr;
   assign src_fire    = src_valid & src_ready;
   assign dst_valid   = (state_q == ST_DRAIN) & ~clr;
   assign dst_fire    = dst_valid & dst_ready;
   assign core_next   = (state_q == ST_REQ) & core_ready & ~clr;
   assign core_block  = enc_q ? (in_blk ^ chain_q) : in_blk;
   assign out_load_en = (state_q == ST_WAIT) & core_valid;
   assign out_load    = enc_q ? core_result : (core_result ^ chain_q);
   assign dst_data    = out_blk[DOE_BLK_W-1 -: DATA_WIDTH];
   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);
   assign error       = err_q;
   assign dbg_state_o = state_q;

   always_comb begin
      state_d = state_q;
      enc_d   = enc_q;
      cnt_d   = cnt_q;
      chain_d = chain_q;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (num_blocks != '0) begin
                  enc_d   = encdec;
                  cnt_d   = num_blocks;
                  chain_d = iv;
                  state_d = ST_LOAD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_LOAD:  if (src_fire && in_last) state_d = ST_REQ;
         ST_REQ:   if (core_next) state_d = ST_WAIT;
         ST_WAIT: begin
            if (core_valid) begin
               // Decrypt chains on the ciphertext just consumed, encrypt on the result.
               chain_d = enc_q ? core_result : in_blk;
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (dst_fire && out_last) begin
               if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
               state_d = (cnt_q > BLK_CNT_W'(1)) ? ST_LOAD : ST_DONE;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= ST_IDLE;
         enc_q   <= 1'b0;
         cnt_q   <= '0;
         chain_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         enc_q   <= enc_d;
         cnt_q   <= cnt_d;
         chain_q <= chain_d;
         err_q   <= err_d;
      end
   end

   doe_blk_shifter #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
      .clk        (clk),
      .clr_i      (clr),
      .load_i     (1'b0),
      .load_blk_i ('0),
      .shift_i    (src_fire),
      .word_i     (src_data),
      .blk_o      (in_blk),
      .last_o     (in_last)
   );

   doe_blk_shifter #(.DATA_WIDTH(DATA_WIDTH)) u_unpacker (
      .clk        (clk),
      .clr_i      (clr),
      .load_i     (out_load_en),
      .load_blk_i (out_load),
      .shift_i    (dst_fire),
      .word_i     ('0),
      .blk_o      (out_blk),
      .last_o     (out_last)
   );

endmodule

// File: tb/tb_doe_cbc_chain.sv
// Bench for doe_cbc_chain at 32- and 64-bit word widths with a stub XOR core
// and a block-level CBC reference model.
module tb_doe_cbc_chain;
   import doe_defines_pkg::*;

   localparam logic [127:0] PAD = {16{8'hA5}};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst = 1'b1;
   logic         encdec = 1'b0;
   logic [7:0]   num_blocks = '0;
   logic [127:0] iv = '0;
   logic         start_a[2];
   logic         zeroize_a[2];

   logic             busy_a[2], done_a[2], error_a[2], src_ready_a[2], dst_valid_a[2], core_next_a[2];
   logic [63:0]      dst_data_a[2];
   logic [127:0]     core_block_a[2], chain_a[2];
   doe_chain_state_e state_a[2];

   int nchk = 0;
   int nerr = 0;

   logic [127:0] job_blk[32], exp_out[32], exp_core[32], cap_out[32], cap_core[32];
   int job_n = 0;
   int act   = -1;
   bit rnd = 1'b0, stall_dst = 1'b0, stall_core = 1'b0;
   int widx = 0, didx = 0, ncore = 0, ndone = 0;

   task automatic chk(input string name, input logic [127:0] actual, input logic [127:0] expected);
      nchk++;
      if (actual !== expected) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   function automatic logic [63:0] word_of(input logic [127:0] b, input int w, input int k);
      logic [127:0] t;
      t = b >> (128 - (k + 1) * w);
      return (w == 64) ? t[63:0] : {32'h0, t[31:0]};
   endfunction

   for (genvar g = 0; g < 2; g++) begin : gen_dut
      localparam int W   = (g == 0) ? 32 : 64;
      localparam int WPB = 128 / W;

      logic             src_valid = 1'b0, dst_ready = 1'b0, core_ready = 1'b0, core_valid = 1'b0;
      logic             src_ready, dst_valid, core_next, busy, done, error;
      logic [W-1:0]     src_data = '0;
      logic [W-1:0]     dst_data;
      logic [W-1:0]     held_data = '0;
      logic [127:0]     core_block;
      logic [127:0]     core_result = '0, issued = '0, acc = '0;
      doe_chain_state_e dbg_state;
      bit               held = 1'b0;
      int               lat = 0, dhold = 0, chold = 0;

      doe_cbc_chain #(.DATA_WIDTH(W), .BLK_CNT_W(8)) u_dut (
         .clk         (clk),
         .rst         (rst),
         .zeroize     (zeroize_a[g]),
         .start       (start_a[g]),
         .encdec      (encdec),
         .num_blocks  (num_blocks),
         .iv          (iv),
         .busy        (busy),
         .done        (done),
         .error       (error),
         .src_valid   (src_valid),
         .src_ready   (src_ready),
         .src_data    (src_data),
         .dst_valid   (dst_valid),
         .dst_ready   (dst_ready),
         .dst_data    (dst_data),
         .core_next   (core_next),
         .core_block  (core_block),
         .core_ready  (core_ready),
         .core_result (core_result),
         .core_valid  (core_valid),
         .dbg_state_o (dbg_state)
      );

      assign busy_a[g]       = busy;
      assign done_a[g]       = done;
      assign error_a[g]      = error;
      assign src_ready_a[g]  = src_ready;
      assign dst_valid_a[g]  = dst_valid;
      assign core_next_a[g]  = core_next;
      assign dst_data_a[g]   = 64'(dst_data);
      assign core_block_a[g] = core_block;
      assign state_a[g]      = dbg_state;
      assign chain_a[g]      = u_dut.chain_q;

      // Drive inputs on the falling edge, then observe the settled cycle.
      always @(negedge clk) begin
         src_valid = (act == g) && (widx < job_n * WPB) && (!rnd || $urandom_range(0, 3) != 0);
         src_data  = W'(word_of(job_blk[widx / WPB], W, widx % WPB));
         if (dhold > 0) begin
            dst_ready = 1'b0;
            dhold--;
         end else begin
            dst_ready = !rnd || ($urandom_range(0, 2) != 0);
         end
         if (chold > 0) begin
            core_ready = 1'b0;
            chold--;
         end else begin
            core_ready = 1'b1;
         end
         core_valid = (lat == 1);
         #1;
         if (held && dst_valid) chk("dst_hold", 128'(dst_data), 128'(held_data));
         held      = dst_valid && !dst_ready;
         held_data = dst_data;
         if (src_valid && src_ready) begin
            if (stall_core && (widx % WPB) == WPB - 1) begin
               chold      = 4;
               stall_core = 1'b0;
            end
            widx++;
         end
         if (dst_valid && dst_ready) begin
            chk("dst_word", 128'(dst_data), 128'(W'(word_of(exp_out[didx / WPB], W, didx % WPB))));
            acc = (acc << W) | 128'(dst_data);
            if ((didx % WPB) == WPB - 1) cap_out[didx / WPB] = acc;
            if (stall_dst && (didx % WPB) == 0) begin
               dhold     = 5;
               stall_dst = 1'b0;
            end
            didx++;
         end
         if (core_next) begin
            chk("core_next_ready", 128'(core_ready), 128'(1));
            chk("core_next_in_req", 128'(dbg_state), 128'(ST_REQ));
            chk("core_block", core_block, exp_core[ncore]);
            cap_core[ncore] = core_block;
            ncore++;
            issued      = core_block;
            core_result = core_block ^ PAD;
            lat         = 3;
         end else if (lat > 0) begin
            lat--;
         end
         if (dbg_state == ST_WAIT) chk("core_block_stable", core_block, issued);
         if (done) ndone++;
      end
   end

   task automatic build_model(input bit enc, input int n, input logic [127:0] ivv);
      logic [127:0] c;
      c = ivv;
      for (int i = 0; i < n; i++) begin
         if (enc) begin
            exp_core[i] = job_blk[i] ^ c;
            exp_out[i]  = exp_core[i] ^ PAD;
            c           = exp_out[i];
         end else begin
            exp_core[i] = job_blk[i];
            exp_out[i]  = job_blk[i] ^ PAD ^ c;
            c           = job_blk[i];
         end
      end
   endtask

   task automatic fill_rand(input int n);
      for (int i = 0; i < n; i++) job_blk[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
   endtask

   task automatic start_job(input int g, input bit enc, input int n, input logic [127:0] ivv,
                            input bit sd, input bit sc);
      build_model(enc, n, ivv);
      @(negedge clk);
      widx = 0; didx = 0; ncore = 0; ndone = 0;
      job_n = n; act = g; stall_dst = sd; stall_core = sc;
      encdec = enc; num_blocks = 8'(n); iv = ivv; start_a[g] = 1'b1;
      @(negedge clk);
      start_a[g] = 1'b0;
      #2;
      chk("busy_after_start", 128'(busy_a[g]), 128'(1));
      chk("state_load", 128'(state_a[g]), 128'(ST_LOAD));
   endtask

   task automatic run_job(input int g, input bit enc, input int n, input logic [127:0] ivv,
                          input bit sd, input bit sc);
      int cyc;
      start_job(g, enc, n, ivv, sd, sc);
      cyc = 0;
      while (ndone == 0 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      #2;
      chk("done_seen", 128'(ndone), 128'(1));
      chk("busy_after_done", 128'(busy_a[g]), 128'(0));
      repeat (3) @(negedge clk);
      #2;
      chk("done_once", 128'(ndone), 128'(1));
      chk("words_out", 128'(didx), 128'(n * ((g == 0) ? 4 : 2)));
      chk("core_reqs", 128'(ncore), 128'(n));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

   initial begin
      int cyc;
      logic [127:0] v;
      for (int g = 0; g < 2; g++) begin
         start_a[g]   = 1'b0;
         zeroize_a[g] = 1'b0;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #2;
      for (int g = 0; g < 2; g++) begin
         chk("rst_busy", 128'(busy_a[g]), 128'(0));
         chk("rst_done", 128'(done_a[g]), 128'(0));
         chk("rst_error", 128'(error_a[g]), 128'(0));
         chk("rst_src_ready", 128'(src_ready_a[g]), 128'(0));
         chk("rst_dst_valid", 128'(dst_valid_a[g]), 128'(0));
         chk("rst_core_next", 128'(core_next_a[g]), 128'(0));
         chk("rst_dst_data", 128'(dst_data_a[g]), 128'(0));
         chk("rst_core_block", core_block_a[g], 128'(0));
         chk("rst_chain", chain_a[g], 128'(0));
         chk("rst_state", 128'(state_a[g]), 128'(ST_IDLE));
      end

      for (int g = 0; g < 2; g++) begin
         // Known-answer decrypt: block ^ iv is all 0F, so the result is all AA.
         rnd = 1'b0;
         job_blk[0] = 128'h000102030405060708090A0B0C0D0E0F;
         run_job(g, 1'b0, 1, 128'h0F0E0D0C0B0A09080706050403020100, 1'b0, 1'b0);
         chk("model_kat", exp_out[0], {16{8'hAA}});
         chk("dut_kat", cap_out[0], {16{8'hAA}});

         // Two-block encrypt: second core input chains on the first result.
         fill_rand(2);
         v = {$urandom(), $urandom(), $urandom(), $urandom()};
         run_job(g, 1'b1, 2, v, 1'b0, 1'b0);
         chk("enc_chain", cap_core[1], cap_out[0] ^ job_blk[1]);
         chk("enc_first_in", cap_core[0], job_blk[0] ^ v);

         // Zero-length job is rejected with a one-cycle error.
         @(negedge clk);
         act = g; job_n = 0; widx = 0; num_blocks = 8'd0; start_a[g] = 1'b1;
         @(negedge clk);
         start_a[g] = 1'b0;
         #2;
         chk("err_pulse", 128'(error_a[g]), 128'(1));
         chk("err_busy", 128'(busy_a[g]), 128'(0));
         chk("err_src_ready", 128'(src_ready_a[g]), 128'(0));
         @(negedge clk);
         #2;
         chk("err_single", 128'(error_a[g]), 128'(0));
         chk("err_idle", 128'(state_a[g]), 128'(ST_IDLE));
         chk("err_src_ready2", 128'(src_ready_a[g]), 128'(0));

         // Output and core back-pressure.
         fill_rand(2);
         run_job(g, 1'b1, 2, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, 1'b1);
         fill_rand(2);
         run_job(g, 1'b0, 2, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, 1'b1);

         // Wipe while waiting on the core; the late core_valid must be ignored.
         fill_rand(1);
         start_job(g, 1'b1, 1, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 1'b0);
         cyc = 0;
         while (ncore == 0 && cyc < 500) begin
            @(negedge clk);
            cyc++;
         end
         #2;
         chk("zero_in_wait", 128'(state_a[g]), 128'(ST_WAIT));
         zeroize_a[g] = 1'b1;
         @(negedge clk);
         zeroize_a[g] = 1'b0;
         #2;
         chk("zero_idle", 128'(state_a[g]), 128'(ST_IDLE));
         chk("zero_chain", chain_a[g], 128'(0));
         chk("zero_busy", 128'(busy_a[g]), 128'(0));
         for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #2;
            chk("zero_no_dst", 128'(dst_valid_a[g]), 128'(0));
            chk("zero_stay_idle", 128'(state_a[g]), 128'(ST_IDLE));
         end
         chk("zero_no_done", 128'(ndone), 128'(0));
         fill_rand(1);
         run_job(g, 1'b0, 1, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 1'b0);

         // Wipe and start together: start is dropped.
         @(negedge clk);
         job_n = 0; num_blocks = 8'd1; start_a[g] = 1'b1; zeroize_a[g] = 1'b1;
         @(negedge clk);
         start_a[g] = 1'b0; zeroize_a[g] = 1'b0;
         #2;
         chk("zs_idle", 128'(state_a[g]), 128'(ST_IDLE));
         chk("zs_busy", 128'(busy_a[g]), 128'(0));

         // Reset mid-load aborts with no further handshakes.
         fill_rand(2);
         start_job(g, 1'b0, 2, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 1'b0);
         cyc = 0;
         while (widx == 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
         end
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         #2;
         chk("rstmid_idle", 128'(state_a[g]), 128'(ST_IDLE));
         chk("rstmid_chain", chain_a[g], 128'(0));
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            chk("rstmid_no_src", 128'(src_ready_a[g]), 128'(0));
            chk("rstmid_no_core", 128'(core_next_a[g]), 128'(0));
            chk("rstmid_no_dst", 128'(dst_valid_a[g]), 128'(0));
         end

         // Randomised jobs with random stream gaps.
         rnd = 1'b1;
         for (int j = 0; j < 5; j++) begin
            int n;
            n = $urandom_range(1, 4);
            fill_rand(n);
            run_job(g, 1'($urandom_range(0, 1)), n, {$urandom(), $urandom(), $urandom(), $urandom()},
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
         rnd = 1'b0;
         act = -1;
      end

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule

// File: doc/doe_cbc_chain.md
DOE_CBC_CHAIN -- requirements
Module: doe_cbc_chain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning stream word width; legal values are 32 and 64.
REQ-002 SHALL have parameter BLK_CNT_W, default 8, meaning width of the per-job block count.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port zeroize, input, 1 bit: synchronous wipe of all state.
REQ-006 SHALL have port start, input, 1 bit: single-cycle job request.
REQ-007 SHALL have port encdec, input, 1 bit: 1 selects encrypt, 0 selects decrypt; sampled on accepted start.
REQ-008 SHALL have port num_blocks, input, BLK_CNT_W bits: blocks in the job; sampled on accepted start.
REQ-009 SHALL have port iv, input, 128 bits: initial chaining value; sampled on accepted start.
REQ-010 SHALL have port busy, output, 1 bit: high from accepted start until the cycle after done.
REQ-011 SHALL have port done, output, 1 bit: single-cycle job-complete pulse.
REQ-012 SHALL have port error, output, 1 bit: single-cycle pulse when a job is rejected.
REQ-013 SHALL have src_valid (input, 1), src_ready (output, 1) and src_data (input, DATA_WIDTH): the input word stream.
REQ-014 SHALL have dst_valid (output, 1), dst_ready (input, 1) and dst_data (output, DATA_WIDTH): the output word stream.
REQ-015 SHALL have core_next (output, 1), core_block (output, 128), core_ready (input, 1), core_result (input, 128) and core_valid (input, 1): the AES core handshake.

Function
REQ-016 WPB SHALL equal 128/DATA_WIDTH; the first word of a block SHALL occupy block bits [127:128-DATA_WIDTH], with later words filling downward.
REQ-017 FSM states SHALL be IDLE, LOAD, REQ, WAIT, DRAIN and DONE.
REQ-018 In IDLE, start with num_blocks≠0 SHALL latch encdec, num_blocks and iv (as chain_reg), then go to LOAD next cycle.
REQ-019 In IDLE, start with num_blocks==0 SHALL pulse error the next cycle and remain in IDLE.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 src_ready SHALL be 1 only in LOAD; a word transfers when src_valid&&src_ready.
REQ-022 LOAD SHALL go to REQ in the cycle after the WPB-th word transfers.
REQ-023 core_block SHALL be (in_blk XOR chain_reg) when encrypting and in_blk when decrypting.
REQ-024 core_block SHALL be held stable from entry to REQ until WAIT exits.
REQ-025 In REQ, core_next SHALL pulse for exactly one cycle, and only in a cycle with core_ready==1; the FSM then goes to WAIT.
REQ-026 While core_ready==0, the FSM SHALL stay in REQ.
REQ-027 In WAIT, on core_valid:
- encrypt: out_blk <= core_result; chain_reg <= core_result.
- decrypt: out_blk <= core_result XOR chain_reg; chain_reg <= in_blk.
- then go to DRAIN.
REQ-028 core_valid outside WAIT SHALL be ignored.
REQ-029 In DRAIN, dst_valid SHALL be 1 and dst_data SHALL be the current word of out_blk, MS word first.
REQ-030 dst_data SHALL hold stable while dst_valid&&!dst_ready.
REQ-031 After the WPB-th word transfers, the block counter SHALL decrement; the FSM SHALL go to LOAD if the count is nonzero, otherwise to DONE.
REQ-032 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-033 The word counter SHALL wrap to 0 at WPB; the block counter SHALL never underflow.
REQ-034 zeroize SHALL take priority over all other events: all registers cleared, state=IDLE, no done or error pulse.
REQ-035 zeroize and start in the same cycle: start SHALL be dropped.
REQ-036 Minimum per-block latency SHALL be WPB+1 (load) + 1 (REQ) + core latency + WPB (drain) cycles.

Reset
REQ-037 rst SHALL have the same effect as zeroize, evaluated at the clk edge.
REQ-038 After reset:
- busy, done, error, src_ready, dst_valid and core_next SHALL be 0.
- dst_data and core_block SHALL be 0.
- chain_reg, in_blk, out_blk and all counters SHALL be 0.
REQ-039 rst asserted mid-job SHALL abort the job with no further stream or core handshakes.

Structure
REQ-040 doe_defines_pkg SHALL hold DOE_BLK_W=128 and the enum doe_chain_state_e.
REQ-041 One sub-module, doe_blk_shifter, SHALL be parametrised on DATA_WIDTH and instantiated twice: as packer (in_blk) and unpacker (out_blk).
REQ-042 The module SHALL contain no AES logic; the core is external.

Verification
REQ-043 The bench SHALL use a stub core with core_result = core_block XOR {16{8'hA5}} and 3-cycle latency.
REQ-044 Decrypt, 1 block, iv=128'h0F0E..00, src words 32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F -> dst = src XOR A5.. XOR iv; done pulses once.
REQ-045 Encrypt, 2 blocks, DATA_WIDTH=64 -> block 2's core_block equals block 1's result XOR its plaintext; outputs match a reference model.
REQ-046 num_blocks=0 with start -> error pulses 1 cycle later; busy stays 0; no src_ready.
REQ-047 dst_ready held low 5 cycles mid-DRAIN, and core_ready low 4 cycles in REQ -> dst_data stable, core_next issued exactly once, result correct.
REQ-048 zeroize asserted in WAIT -> next cycle state=IDLE, chain_reg=0, no done; a later core_valid is ignored; a new job completes correctly.
